// File: rtl/aqp_esp_uart_pkg.sv
// Shared definitions for the ESP32 UART link (RX and TX sides).
// State encoding and FIFO word layout.
package aqp_esp_uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam int WRDATA_FERR_BIT = 8;

endpackage

// File: rtl/aqp_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL selects the value both flops take during reset.
module aqp_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/aqp_esp_uart_rx.sv
// ESP32 8N1 UART receiver feeding the ESP RX FIFO, with RTS and overrun.
// Define AQP_ESP_UART_RX_MAJORITY_EN for 3-sample majority voting (BAUD_DIV >= 6).
module aqp_esp_uart_rx
    import aqp_esp_uart_pkg::*;
#(
    parameter int BAUD_DIV = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       fifo_full,
    input  logic       fifo_almost_full,
    output logic [8:0] wrdata,
    output logic       wr_en,
    output logic       rts_n,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic rxs;
    logic samp;

    aqp_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxs)
    );

`ifdef AQP_ESP_UART_RX_MAJORITY_EN
    // Decisions happen one cycle late, on the +1 sample; hist_q holds -1 and 0.
    localparam logic [CW-1:0] CNT_START = CW'(BAUD_DIV / 2);

    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign samp = (hist_q[1] & hist_q[0]) |
                  (hist_q[1] & rxs) |
                  (hist_q[0] & rxs);
`else
    localparam logic [CW-1:0] CNT_START = CW'(BAUD_DIV / 2 - 1);

    assign samp = rxs;
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [8:0]    wrdata_q, wrdata_d;
    logic          wr_en_q, wr_en_d;
    logic          overrun_q, overrun_d;
    logic          rts_n_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        wrdata_d = wrdata_q;
        wr_en_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = samp ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {samp, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d                     = '0;
                    wr_en_d                   = 1'b1;
                    wrdata_d[WRDATA_FERR_BIT] = ~samp;
                    wrdata_d[7:0]             = shreg_q;
                    state_d = samp ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                // A held-low line produces one error word, then waits here.
                cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set has priority over clear so a coincident overrun is not lost.
    assign overrun_d = (wr_en_q & fifo_full) | (overrun_q & ~overrun_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            wrdata_q  <= '0;
            wr_en_q   <= 1'b0;
            overrun_q <= 1'b0;
            rts_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            wrdata_q  <= wrdata_d;
            wr_en_q   <= wr_en_d;
            overrun_q <= overrun_d;
            rts_n_q   <= fifo_almost_full;
        end
    end

    assign wrdata  = wrdata_q;
    assign wr_en   = wr_en_q;
    assign rts_n   = rts_n_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aqp_esp_uart_rx.sv
// Scoreboard bench for aqp_esp_uart_rx: random and directed 8N1 frames.
// Expected FIFO words are queued by the driver and checked by a monitor.
module tb_aqp_esp_uart_rx;

    localparam int BD = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       fifo_full = 1'b0;
    logic       fifo_almost_full = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [8:0] wrdata;
    logic       wr_en;
    logic       rts_n;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] expq[$];
    logic wr_en_prev = 1'b0;

    aqp_esp_uart_rx #(.BAUD_DIV(BD)) dut (
        .clk              (clk),
        .reset            (reset),
        .rxd              (rxd),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .wrdata           (wrdata),
        .wr_en            (wr_en),
        .rts_n            (rts_n),
        .overrun          (overrun),
        .overrun_clr      (overrun_clr),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (wr_en_prev) chk("wr_en_back2back", 32'(wr_en_prev), 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_strobe", 32'(expq.size()), 32'd1);
            end else begin
                chk("wrdata", 32'(wrdata), 32'(expq.pop_front()));
            end
        end
        wr_en_prev <= !reset && wr_en;
    end

    // One bit time; optional inverted 1-clk spike at mid-bit.
    task automatic drive_bit(input logic v, input logic spike,
                             input logic clr_on_strobe);
        for (int k = 0; k < BD; k++) begin
            @(negedge clk);
            rxd = (spike && k == BD / 2) ? ~v : v;
            overrun_clr = clr_on_strobe && wr_en;
        end
    endtask

    // Reference: each data bit is what the line holds at mid-bit,
    // unless majority voting filters a single-clock spike.
    function automatic logic [7:0] seen_byte(input logic [7:0] b,
                                             input logic spike);
`ifdef AQP_ESP_UART_RX_MAJORITY_EN
        return b;
`else
        return spike ? ~b : b;
`endif
    endfunction

    task automatic send_char(input logic [7:0] b, input logic stop,
                             input logic spike, input logic clr);
        expq.push_back({~stop, seen_byte(b, spike)});
        drive_bit(1'b0, 1'b0, clr);
        for (int i = 0; i < 8; i++) drive_bit(b[i], spike, clr);
        drive_bit(stop, 1'b0, clr);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 * BD && expq.size() != 0; i++) @(negedge clk);
        chk(nm, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        logic       st;
        logic [7:0] f0;
        int         t;

        repeat (4) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wrdata", 32'(wrdata), 32'd0);
        chk("rst_rts_n", 32'(rts_n), 32'd1);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rts_after_reset", 32'(rts_n), 32'd0);
        repeat (BD) @(negedge clk);

        send_char(8'hA5, 1'b1, 1'b0, 1'b0);
        send_char(8'h3C, 1'b1, 1'b0, 1'b0);
        drain("drain_a5_3c");
        chk("overrun_idle", 32'(overrun), 32'd0);

        // Low glitch on an idle line must be rejected.
        repeat (3) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        @(negedge clk);
        rxd = 1'b1;
        t = 0;
        while (busy && t < BD / 2 + 4) begin
            @(negedge clk);
            t++;
        end
        chk("glitch_busy", 32'(busy), 32'd0);
        repeat (2 * BD) @(negedge clk);

        // Framing error followed by a long break.
        send_char(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (40) drive_bit(1'b0, 1'b0, 1'b0);
        chk("break_busy", 32'(busy), 32'd1);
        chk("break_one_word", 32'(expq.size()), 32'd0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_exit_busy", 32'(busy), 32'd0);
        repeat (2 * BD) @(negedge clk);

        // Randomised frames, occasional framing errors and gaps.
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 5) != 0);
            send_char(b, st, 1'b0, 1'b0);
            if (!st) begin
                repeat ($urandom_range(0, 3)) drive_bit(1'b0, 1'b0, 1'b0);
                drive_bit(1'b1, 1'b0, 1'b0);
                drive_bit(1'b1, 1'b0, 1'b0);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        drain("drain_random");
        chk("overrun_random", 32'(overrun), 32'd0);

        // Overrun set, clear, and set-wins-over-clear.
        fifo_full = 1'b1;
        send_char(8'h81, 1'b1, 1'b0, 1'b0);
        drain("drain_81");
        chk("overrun_set", 32'(overrun), 32'd1);
        fifo_full = 1'b0;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("overrun_clr", 32'(overrun), 32'd0);
        fifo_full = 1'b1;
        send_char(8'h42, 1'b1, 1'b0, 1'b1);
        drain("drain_42");
        overrun_clr = 1'b0;
        fifo_full = 1'b0;
        chk("overrun_set_wins", 32'(overrun), 32'd1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        // RTS follows almost-full one clock later.
        fifo_almost_full = 1'b1;
        chk("rts_pre_rise", 32'(rts_n), 32'd0);
        @(negedge clk);
        chk("rts_rise", 32'(rts_n), 32'd1);
        fifo_almost_full = 1'b0;
        chk("rts_pre_fall", 32'(rts_n), 32'd1);
        @(negedge clk);
        chk("rts_fall", 32'(rts_n), 32'd0);

        // Reset in data bit 4 of 0xF0 discards the partial character.
        f0 = 8'hF0;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(f0[i], 1'b0, 1'b0);
        repeat (BD / 2) begin
            @(negedge clk);
            rxd = f0[4];
        end
        reset = 1'b1;
        rxd = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_rts_n", 32'(rts_n), 32'd1);
        chk("midrst_wrdata", 32'(wrdata), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BD) @(negedge clk);
        send_char(8'h12, 1'b1, 1'b0, 1'b0);
        drain("drain_12");

        // Mid-bit spikes: filtered with voting, inverted without.
        repeat (BD) @(negedge clk);
        send_char(8'h96, 1'b1, 1'b1, 1'b0);
        drain("drain_96");
        repeat (2 * BD) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
